// File: rtl/uart_pkg.sv
// Shared constants, receiver FSM encoding and the parity helper for uart_rx_os.
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_EVEN = 2'd1;
  localparam logic [1:0] PARITY_ODD  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_t;

  // Parity bit a transmitter would append to the (zero-extended) data word.
  function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
    logic p;
    p = 1'b0;
    case (mode)
      PARITY_EVEN: p = ^data;
      PARITY_ODD:  p = ~^data;
      default:     p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every CLK_DIV clocks; restart realigns phase.
// Tick is combinational from the counter; no backpressure.
module uart_baud_tick #(
  parameter int CLK_DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart || cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST) && !restart;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority vote and a valid/ready holding register.
// Word commits at the last stop-bit mid; a full, unaccepted holding register drops the frame and pulses rx_overrun.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_DIV     = 27,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_pin_in,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int SW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 0) ? $clog2(DATA_BITS + 1) : 1;
  // samp_q holds the index of the previous sample, so a tick at value k takes sample k+1.
  localparam logic [SW-1:0] SAMP_V0   = SW'(OVERSAMPLE / 2 - 2);
  localparam logic [SW-1:0] SAMP_V1   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS);
  localparam logic [1:0]    PMODE     = 2'(PARITY_MODE);
  localparam logic          HAS_PAR   = (PMODE != PARITY_NONE);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  logic       sync1_q, sync2_q, line_prev_q;
  logic [1:0] warm_q;
  logic       fall, restart, tick, maj;

  rx_state_t            state_q;
  logic [SW-1:0]        samp_q;
  logic [BW-1:0]        bitcnt_q;
  logic                 stop_q;
  logic [1:0]           v_q;
  logic [DATA_BITS-1:0] sh_q;
  logic                 perr_q, ferr_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, rx_perr_q, rx_ferr_q, rx_ovr_q;

  // line_prev_q only arms once the synchronizer carries a real post-reset high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      warm_q      <= '0;
      line_prev_q <= 1'b0;
    end else begin
      sync1_q     <= rx_pin_in;
      sync2_q     <= sync1_q;
      warm_q      <= {warm_q[0], 1'b1};
      line_prev_q <= warm_q[1] & sync2_q;
    end
  end

  assign fall    = line_prev_q & ~sync2_q;
  assign restart = (state_q == ST_IDLE) && fall;
  assign maj     = (v_q[0] & v_q[1]) | (v_q[0] & sync2_q) | (v_q[1] & sync2_q);

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      samp_q     <= '0;
      bitcnt_q   <= '0;
      stop_q     <= 1'b0;
      v_q        <= '0;
      sh_q       <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_ovr_q <= 1'b0;
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (fall) begin
            state_q  <= ST_START;
            samp_q   <= '0;
            bitcnt_q <= '0;
            stop_q   <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
          end
        end
        ST_WAIT_HIGH: begin
          if (sync2_q) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          if (tick) begin
            samp_q <= (samp_q == SAMP_LAST) ? '0 : samp_q + 1'b1;
            if (samp_q == SAMP_V0) v_q[0] <= sync2_q;
            if (samp_q == SAMP_V1) v_q[1] <= sync2_q;
            if (samp_q == SAMP_MID) begin
              case (state_q)
                ST_START: begin
                  if (maj) state_q <= ST_IDLE;
                end
                ST_DATA: begin
                  sh_q     <= {maj, sh_q[DATA_BITS-1:1]};
                  bitcnt_q <= bitcnt_q + 1'b1;
                end
                ST_PARITY: begin
                  perr_q <= maj ^ parity_bit(9'(sh_q), PMODE);
                end
                ST_STOP: begin
                  ferr_q <= ferr_q | ~maj;
                  stop_q <= 1'b1;
                  if (stop_q == STOP_LAST) begin
                    state_q <= (ferr_q | ~maj) ? ST_WAIT_HIGH : ST_IDLE;
                    if (!rx_valid_q || rx_ready) begin
                      rx_data_q  <= sh_q;
                      rx_perr_q  <= perr_q;
                      rx_ferr_q  <= ferr_q | ~maj;
                      rx_valid_q <= 1'b1;
                    end else begin
                      rx_ovr_q <= 1'b1;
                    end
                  end
                end
                default: ;
              endcase
            end
            if (samp_q == SAMP_LAST) begin
              case (state_q)
                ST_START:  state_q <= ST_DATA;
                ST_DATA: begin
                  if (bitcnt_q == BITS_LAST) state_q <= HAS_PAR ? ST_PARITY : ST_STOP;
                end
                ST_PARITY: state_q <= ST_STOP;
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = rx_ovr_q;
  assign rx_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: instance 0 is 8N1, 1 is 8E1, 2 is 7N2; all at 64 clk per bit.
module tb_uart_rx_os;

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       par;
    logic       stop0;
    logic       stop1;
    logic       glitch;
    logic [8:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line  [3];
  logic ready [3];
  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic vld [3], perr [3], ferr [3], ovr [3], busy [3];
  logic [8:0] dat [3];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ncommit [3] = '{0, 0, 0};
  int novr    [3] = '{0, 0, 0};
  int cap_cyc [3] = '{0, 0, 0};
  logic [8:0] cap_data [3];
  logic cap_perr [3], cap_ferr [3];
  logic vld_prev [3] = '{1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_os #(.CLK_DIV(4), .OVERSAMPLE(16)) u_a (
    .clk(clk), .rst(rst), .rx_pin_in(line[0]), .rx_ready(ready[0]), .rx_data(data_a),
    .rx_valid(vld[0]), .rx_parity_err(perr[0]), .rx_frame_err(ferr[0]),
    .rx_overrun(ovr[0]), .rx_busy(busy[0]));

  uart_rx_os #(.CLK_DIV(4), .OVERSAMPLE(16), .PARITY_MODE(1)) u_b (
    .clk(clk), .rst(rst), .rx_pin_in(line[1]), .rx_ready(ready[1]), .rx_data(data_b),
    .rx_valid(vld[1]), .rx_parity_err(perr[1]), .rx_frame_err(ferr[1]),
    .rx_overrun(ovr[1]), .rx_busy(busy[1]));

  uart_rx_os #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(7), .STOP_BITS(2)) u_c (
    .clk(clk), .rst(rst), .rx_pin_in(line[2]), .rx_ready(ready[2]), .rx_data(data_c),
    .rx_valid(vld[2]), .rx_parity_err(perr[2]), .rx_frame_err(ferr[2]),
    .rx_overrun(ovr[2]), .rx_busy(busy[2]));

  assign dat[0] = {1'b0, data_a};
  assign dat[1] = {1'b0, data_b};
  assign dat[2] = {2'b00, data_c};

  // Capture each commit (rising rx_valid) and count overrun cycles.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i] && !vld_prev[i]) begin
        ncommit[i]++;
        cap_data[i] = dat[i];
        cap_perr[i] = perr[i];
        cap_ferr[i] = ferr[i];
        cap_cyc[i]  = cyc;
      end
      if (ovr[i]) novr[i]++;
      vld_prev[i] = vld[i];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int inst, input logic [8:0] d, input logic par,
                              input logic s0, input logic s1, input logic g,
                              input logic [8:0] ed, input logic ep, input logic ef);
    vec_t v;
    v.inst = inst; v.data = d; v.par = par; v.stop0 = s0; v.stop1 = s1; v.glitch = g;
    v.exp_data = ed; v.exp_perr = ep; v.exp_ferr = ef;
    return v;
  endfunction

  task automatic build_frame(input vec_t v, output logic [15:0] bits, output int nb);
    int nd;
    nd   = (v.inst == 2) ? 7 : 8;
    bits = '0;
    nb   = 1;
    for (int i = 0; i < nd; i++) begin
      bits[nb] = v.data[i];
      nb++;
    end
    if (v.inst == 1) begin
      bits[nb] = v.par;
      nb++;
    end
    bits[nb] = v.stop0;
    nb++;
    if (v.inst == 2) begin
      bits[nb] = v.stop1;
      nb++;
    end
  endtask

  // One-tick (4 clk) inversion around the bit centre corrupts only the middle vote sample.
  task automatic drive_bits(input int inst, input logic [15:0] bits, input int nb, input logic glitch);
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < 64; c++) begin
        line[inst] = (glitch && c >= 32 && c < 36) ? ~bits[b] : bits[b];
        @(posedge clk);
        #1;
      end
    end
    line[inst] = 1'b1;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    logic [15:0] bits;
    int nb, c0, t0, exp_lat;
    build_frame(v, bits, nb);
    c0 = ncommit[v.inst];
    t0 = cyc;
    drive_bits(v.inst, bits, nb, v.glitch);
    wait_clk(64);
    exp_lat = 3 + 64 * (nb - 1) + 35;
    check({tag, " commits"}, ncommit[v.inst] - c0, 1);
    check({tag, " data"}, cap_data[v.inst], v.exp_data);
    check({tag, " parity_err"}, cap_perr[v.inst], v.exp_perr);
    check({tag, " frame_err"}, cap_ferr[v.inst], v.exp_ferr);
    check_range({tag, " latency"}, cap_cyc[v.inst] - t0, exp_lat - 2, exp_lat + 2);
  endtask

  initial begin
    vec_t vecs [8];
    vec_t v;
    logic [15:0] bits;
    int nb, c0, o0;

    vecs[0] = mk(0, 9'h055, 1'b0, 1'b1, 1'b1, 1'b1, 9'h055, 1'b0, 1'b0);
    vecs[1] = mk(0, 9'h0A7, 1'b0, 1'b1, 1'b1, 1'b0, 9'h0A7, 1'b0, 1'b0);
    vecs[2] = mk(1, 9'h0A3, 1'b1, 1'b1, 1'b1, 1'b0, 9'h0A3, 1'b1, 1'b0);
    vecs[3] = mk(1, 9'h0A3, 1'b0, 1'b1, 1'b1, 1'b0, 9'h0A3, 1'b0, 1'b0);
    vecs[4] = mk(1, 9'h007, 1'b1, 1'b1, 1'b1, 1'b1, 9'h007, 1'b0, 1'b0);
    vecs[5] = mk(0, 9'h081, 1'b0, 1'b0, 1'b1, 1'b0, 9'h081, 1'b0, 1'b1);
    vecs[6] = mk(2, 9'h05A, 1'b0, 1'b1, 1'b1, 1'b1, 9'h05A, 1'b0, 1'b0);
    vecs[7] = mk(2, 9'h025, 1'b0, 1'b1, 1'b0, 1'b0, 9'h025, 1'b0, 1'b1);

    for (int i = 0; i < 3; i++) begin
      line[i]  = 1'b1;
      ready[i] = 1'b1;
    end
    rst = 1'b1;
    wait_clk(3);
    check("reset data", dat[0], 0);
    check("reset valid", vld[0], 0);
    check("reset parity_err", perr[0], 0);
    check("reset frame_err", ferr[0], 0);
    check("reset overrun", ovr[0], 0);
    check("reset busy", busy[2], 0);
    rst = 1'b0;
    wait_clk(20);

    // False start: 20-clk low pulse is rejected at the start-bit vote.
    c0 = ncommit[0];
    line[0] = 1'b0;
    wait_clk(10);
    check("false start busy rises", busy[0], 1);
    wait_clk(10);
    line[0] = 1'b1;
    wait_clk(30);
    check("false start busy drops", busy[0], 0);
    wait_clk(64);
    check("false start no commit", ncommit[0] - c0, 0);
    run_vec("after false start", mk(0, 9'h081, 1'b0, 1'b1, 1'b1, 1'b0, 9'h081, 1'b0, 1'b0));

    // Break: 12 bit times low gives one framed-error commit.
    c0 = ncommit[0];
    line[0] = 1'b0;
    wait_clk(64 * 12);
    line[0] = 1'b1;
    wait_clk(128);
    check("break commits", ncommit[0] - c0, 1);
    check("break data", cap_data[0], 0);
    check("break frame_err", cap_ferr[0], 1);
    check("break parity_err", cap_perr[0], 0);
    run_vec("after break", mk(0, 9'h03C, 1'b0, 1'b1, 1'b1, 1'b0, 9'h03C, 1'b0, 1'b0));

    // Overrun: consumer stalled across two frames.
    ready[0] = 1'b0;
    c0 = ncommit[0];
    o0 = novr[0];
    v = mk(0, 9'h011, 1'b0, 1'b1, 1'b1, 1'b0, 9'h011, 1'b0, 1'b0);
    build_frame(v, bits, nb);
    drive_bits(0, bits, nb, 1'b0);
    wait_clk(64);
    check("overrun first commit", ncommit[0] - c0, 1);
    check("overrun first data", dat[0], 9'h011);
    check("overrun none yet", novr[0] - o0, 0);
    v = mk(0, 9'h022, 1'b0, 1'b1, 1'b1, 1'b0, 9'h022, 1'b0, 1'b0);
    build_frame(v, bits, nb);
    drive_bits(0, bits, nb, 1'b0);
    wait_clk(64);
    check("overrun pulse cycles", novr[0] - o0, 1);
    check("overrun held data", dat[0], 9'h011);
    check("overrun valid held", vld[0], 1);
    ready[0] = 1'b1;
    @(negedge clk);
    check("handshake valid before edge", vld[0], 1);
    @(posedge clk);
    #1;
    check("handshake valid cleared", vld[0], 0);
    check("handshake data kept", dat[0], 9'h011);
    wait_clk(20);

    // Reset in data bit 3 while the line stays low through and after reset.
    c0 = ncommit[0];
    line[0] = 1'b0;
    wait_clk(64 * 4 + 20);
    check("midframe busy", busy[0], 1);
    rst = 1'b1;
    #1;
    check("midframe reset data", dat[0], 0);
    check("midframe reset busy", busy[0], 0);
    check("midframe reset valid", vld[0], 0);
    wait_clk(3);
    rst = 1'b0;
    wait_clk(200);
    check("low line no start", busy[0], 0);
    check("low line no commit", ncommit[0] - c0, 0);
    line[0] = 1'b1;
    wait_clk(20);

    for (int i = 0; i < 8; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
